// File: rtl/flash_sample_streamer_pkg.sv
// Shared types and sizing helpers for the flash sample streamer.
// Imported by the interface-facing top and by the word serializer.
package flash_stream_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    EMIT      = 3'd3,
    NEXT      = 3'd4,
    DONE      = 3'd5
  } stream_state_t;

  function automatic int spw(input int data_w, input int sample_w);
    return data_w / sample_w;
  endfunction

  // A single-lane word still needs a one-bit counter.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SPW    = spw(32, 8);
  localparam int DEF_LANE_W = lane_w(DEF_SPW);

endpackage

// File: rtl/flash_sample_streamer_if.sv
// Avalon-MM read-only master bundle between the streamer and the flash controller.
// Signal names mirror the flash port names used at the system level.
interface flash_sample_streamer_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic                  flash_read;
  logic [ADDR_W-1:0]     flash_addr;
  logic [DATA_W/8-1:0]   flash_byteenable;
  logic                  flash_waitrequest;
  logic                  flash_readdatavalid;
  logic [DATA_W-1:0]     flash_readdata;

  modport master (
    output flash_read, flash_addr, flash_byteenable,
    input  flash_waitrequest, flash_readdatavalid, flash_readdata
  );

  modport slave (
    input  flash_read, flash_addr, flash_byteenable,
    output flash_waitrequest, flash_readdatavalid, flash_readdata
  );
endinterface

// File: rtl/flash_sample_streamer_word.sv
// Holds one fetched flash word and walks its sample lanes in either order.
// Lane order is frozen at load time so a direction change only affects the next word.
module flash_word_serializer
  import flash_stream_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [DATA_W-1:0]   word_i,
  input  logic                fwd_i,
  input  logic                adv_i,
  output logic [SAMPLE_W-1:0] lane_o,
  output logic                last_lane_o
);

  localparam int SPW = spw(DATA_W, SAMPLE_W);
  localparam int LW  = lane_w(SPW);
  localparam logic [LW-1:0] LAST_CNT = LW'(SPW - 1);

  logic [DATA_W-1:0]   word_q;
  logic [LW-1:0]       cnt_q;
  logic                fwd_q;
  logic [LW-1:0]       lane_idx_s;
  logic [SAMPLE_W-1:0] lanes_s [SPW];

  for (genvar g = 0; g < SPW; g++) begin : g_lane
    assign lanes_s[g] = word_q[g*SAMPLE_W +: SAMPLE_W];
  end

  // Word, order and lane counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      fwd_q  <= 1'b1;
    end else if (load_i) begin
      word_q <= word_i;
      cnt_q  <= '0;
      fwd_q  <= fwd_i;
    end else if (adv_i) begin
      cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + LW'(1);
    end
  end

  // Reverse order reads the lane counter from the top lane down.
  always_comb begin
    lane_idx_s = '0;
    if (fwd_q) begin
      lane_idx_s = cnt_q;
    end else begin
      lane_idx_s = LAST_CNT - cnt_q;
    end
  end

  assign lane_o      = lanes_s[lane_idx_s];
  assign last_lane_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/flash_sample_streamer.sv
// Walks a flash word range over Avalon-MM and serialises each word into samples
// paced by the audio tick, with loop/one-shot, restart, pause and underrun report.
module flash_sample_streamer
  import flash_stream_pkg::*;
#(
  parameter int              ADDR_W     = 23,
  parameter int              DATA_W     = 32,
  parameter int              SAMPLE_W   = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(32'h0007_FFFF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic                    direction,
  input  logic                    loop_mode,
  input  logic                    restart,
  flash_sample_streamer_if.master flash,
  output logic [SAMPLE_W-1:0]     sample_out,
  output logic                    sample_valid,
  output logic                    done,
  output logic                    wrapped,
  output logic                    underrun
);

  stream_state_t       state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_q;
  logic                pend_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                done_q;
  logic                wrapped_q;
  logic                underrun_q;

  logic [ADDR_W-1:0]   range_start_s;
  logic [ADDR_W-1:0]   step_addr_s;
  logic                at_end_s;
  stream_state_t       resume_state_s;
  logic                ser_load_s;
  logic                ser_adv_s;
  logic                underrun_s;
  logic [SAMPLE_W-1:0] lane_s;
  logic                last_lane_s;

  // Direction-dependent range start (also the wrap target) and address stepper.
  always_comb begin
    range_start_s = START_ADDR;
    step_addr_s   = addr_q;
    at_end_s      = 1'b0;
    if (direction) begin
      range_start_s = START_ADDR;
      step_addr_s   = addr_q + ADDR_W'(1);
      at_end_s      = (addr_q == END_ADDR);
    end else begin
      range_start_s = END_ADDR;
      step_addr_s   = addr_q - ADDR_W'(1);
      at_end_s      = (addr_q == START_ADDR);
    end
  end

  assign resume_state_s = enable ? REQ : IDLE;
  assign ser_load_s = (state_q == WAIT_DATA) && flash.flash_readdatavalid && !(pend_q || restart);
  assign ser_adv_s  = (state_q == EMIT) && sample_tick && !restart;
  assign underrun_s = sample_tick && enable &&
                      ((state_q == REQ) || (state_q == WAIT_DATA) || (state_q == NEXT));

  flash_word_serializer #(
    .DATA_W   (DATA_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ser_load_s),
    .word_i      (flash.flash_readdata),
    .fwd_i       (direction),
    .adv_i       (ser_adv_s),
    .lane_o      (lane_s),
    .last_lane_o (last_lane_s)
  );

  // Streaming FSM with registered bus and sample outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= START_ADDR;
      read_q     <= 1'b0;
      pend_q     <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      wrapped_q  <= 1'b0;
      underrun_q <= underrun_s;
      case (state_q)
        IDLE: begin
          if (restart) begin
            addr_q  <= range_start_s;
            state_q <= resume_state_s;
            read_q  <= enable;
          end else if (enable) begin
            state_q <= REQ;
            read_q  <= 1'b1;
          end
        end
        REQ: begin
          pend_q <= pend_q | restart;
          if (!flash.flash_waitrequest) begin
            state_q <= WAIT_DATA;
            read_q  <= 1'b0;
          end
        end
        // A restart seen during the read is applied only once the data returns.
        WAIT_DATA: begin
          if (flash.flash_readdatavalid) begin
            pend_q <= 1'b0;
            if (pend_q || restart) begin
              addr_q  <= range_start_s;
              state_q <= resume_state_s;
              read_q  <= enable;
            end else begin
              state_q <= EMIT;
            end
          end else begin
            pend_q <= pend_q | restart;
          end
        end
        EMIT: begin
          if (restart) begin
            addr_q  <= range_start_s;
            state_q <= resume_state_s;
            read_q  <= enable;
          end else if (sample_tick) begin
            sample_q <= lane_s;
            valid_q  <= 1'b1;
            if (last_lane_s) begin
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
          if (restart) begin
            addr_q  <= range_start_s;
            state_q <= resume_state_s;
            read_q  <= enable;
          end else if (at_end_s && !loop_mode) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            addr_q    <= at_end_s ? range_start_s : step_addr_s;
            wrapped_q <= at_end_s;
            state_q   <= resume_state_s;
            read_q    <= enable;
          end
        end
        DONE: begin
          if (restart) begin
            addr_q  <= range_start_s;
            state_q <= resume_state_s;
            read_q  <= enable;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          pend_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flash.flash_read       = read_q;
  assign flash.flash_addr       = addr_q;
  assign flash.flash_byteenable = '1;
  assign sample_out             = sample_q;
  assign sample_valid           = valid_q;
  assign done                   = done_q;
  assign wrapped                = wrapped_q;
  assign underrun               = underrun_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed scoreboard bench for flash_sample_streamer on a 4-word range
// with a 2-wait-state flash model returning {a, a+1, a+2, a+3} bytes.
module tb_flash_sample_streamer;
  import flash_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, sample_tick, direction, loop_mode, restart;
  logic [7:0] sample_out;
  logic       sample_valid, done, wrapped, underrun;

  flash_sample_streamer_if #(.ADDR_W(23), .DATA_W(32)) bus ();

  flash_sample_streamer #(
    .ADDR_W(23), .DATA_W(32), .SAMPLE_W(8),
    .START_ADDR(23'd0), .END_ADDR(23'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
    .direction(direction), .loop_mode(loop_mode), .restart(restart),
    .flash(bus.master),
    .sample_out(sample_out), .sample_valid(sample_valid), .done(done),
    .wrapped(wrapped), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tick_period = 0;
  int          tick_ctr = 0;
  int          wrap_cnt = 0;
  int          und_cnt = 0;
  int          snap;
  logic [7:0]  exp_q[$];
  logic [22:0] reads_q[$];

  // Flash model: two wait states, data valid the cycle after acceptance.
  logic [1:0]  ws_q;
  logic        rdv_q;
  logic [31:0] rdata_q;
  logic        inj_rdv = 1'b0;

  function automatic logic [31:0] word_of(input logic [22:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  assign bus.flash_waitrequest   = bus.flash_read && (ws_q != 2'd2);
  assign bus.flash_readdatavalid = rdv_q | inj_rdv;
  assign bus.flash_readdata      = inj_rdv ? 32'hAABB_CCDD : rdata_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q <= 2'd0; rdv_q <= 1'b0; rdata_q <= 32'd0;
    end else begin
      rdv_q <= 1'b0;
      if (bus.flash_read) begin
        if (ws_q != 2'd2) begin
          ws_q <= ws_q + 2'd1;
        end else begin
          ws_q    <= 2'd0;
          rdv_q   <= 1'b1;
          rdata_q <= word_of(bus.flash_addr);
          reads_q.push_back(bus.flash_addr);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Byte lane k of word a is a+3-k; forward emits k=0..3, reverse k=3..0.
  task automatic push_word(input int a, input bit fwd);
    for (int k = 0; k < 4; k++) begin
      int lane;
      lane = fwd ? k : 3 - k;
      exp_q.push_back(8'(a + 3 - lane));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tick_ctr++;
    sample_tick = (tick_period != 0) && (tick_ctr % tick_period == 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && done !== 1'b1; i++) cyc();
    check(tag, done, 1'b1);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc();
    check(tag, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard pop and pulse counters.
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (exp_q.size() == 0) check("sample_unexpected", {24'd0, sample_out}, 32'hFFFF_FFFF);
      else check("sample", {24'd0, sample_out}, {24'd0, exp_q.pop_front()});
    end
    if (wrapped)  wrap_cnt++;
    if (underrun) und_cnt++;
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0;
    direction = 1'b1; loop_mode = 1'b0; restart = 1'b0;
    cycles(3);
    @(negedge clk);
    check("rst_read", bus.flash_read, 1'b0);
    check("rst_addr", bus.flash_addr, 23'd0);
    check("rst_be", bus.flash_byteenable, 4'hF);
    check("rst_out", {sample_out, sample_valid, done, wrapped, underrun}, 12'd0);
    cyc();
    rst_n = 1'b1;

    // Forward one-shot.
    tick_period = 20;
    for (int a = 0; a < 4; a++) push_word(a, 1'b1);
    enable = 1'b1;
    wait_done("fwd_done");
    check("fwd_addr", bus.flash_addr, 23'd3);
    check("fwd_nreads", reads_q.size(), 4);
    for (int i = 0; i < 4; i++) check("fwd_read_addr", reads_q[i], 23'(i));
    cycles(50);
    check("fwd_no_more_reads", reads_q.size(), 4);
    check("fwd_read_idle", bus.flash_read, 1'b0);
    check("fwd_empty", exp_q.size(), 0);

    // Reverse loop: 3,2,1,0 then wrap to 3; pause after the fifth word.
    reads_q.delete();
    wrap_cnt = 0;
    direction = 1'b0; loop_mode = 1'b1;
    push_word(3, 1'b0); push_word(2, 1'b0); push_word(1, 1'b0);
    push_word(0, 1'b0); push_word(3, 1'b0);
    pulse_restart();
    for (int i = 0; i < 4000 && reads_q.size() < 5; i++) cyc();
    enable = 1'b0;
    wait_empty("rev_empty");
    cycles(20);
    check("rev_nreads", reads_q.size(), 5);
    check("rev_r0", reads_q[0], 23'd3);
    check("rev_r1", reads_q[1], 23'd2);
    check("rev_r2", reads_q[2], 23'd1);
    check("rev_r3", reads_q[3], 23'd0);
    check("rev_r4", reads_q[4], 23'd3);
    check("rev_wrapped_once", wrap_cnt, 1);
    check("rev_pause_addr", bus.flash_addr, 23'd2);
    check("rev_pause_read", bus.flash_read, 1'b0);

    // Restart while the read of addr 2 is in WAIT_DATA.
    reads_q.delete();
    direction = 1'b1; loop_mode = 1'b0; enable = 1'b1;
    push_word(0, 1'b1); push_word(1, 1'b1);
    for (int a = 0; a < 4; a++) push_word(a, 1'b1);
    pulse_restart();
    for (int i = 0; i < 4000 && reads_q.size() < 3; i++) cyc();
    check("rs_reached_addr2", reads_q.size() >= 3 ? reads_q[2] : 23'h7FFFFF, 23'd2);
    pulse_restart();
    wait_done("rs_done");
    check("rs_nreads", reads_q.size(), 7);
    check("rs_after_restart_addr", reads_q.size() > 3 ? reads_q[3] : 23'h7FFFFF, 23'd0);
    check("rs_empty", exp_q.size(), 0);

    // Fast ticks: underruns while fetching, no sample lost or repeated.
    reads_q.delete();
    und_cnt = 0;
    tick_period = 3;
    for (int a = 0; a < 4; a++) push_word(a, 1'b1);
    pulse_restart();
    wait_done("fast_done");
    check("fast_empty", exp_q.size(), 0);
    check("fast_underrun_seen", und_cnt != 0, 1'b1);
    cycles(2);
    snap = und_cnt;
    cycles(30);
    check("fast_no_underrun_done", und_cnt, snap);

    // Enable dropped mid-word at addr 1, then resumed.
    reads_q.delete();
    tick_period = 10;
    push_word(0, 1'b1); push_word(1, 1'b1);
    pulse_restart();
    for (int i = 0; i < 4000 && exp_q.size() > 3; i++) cyc();
    enable = 1'b0;
    wait_empty("pause_empty");
    cycles(30);
    check("pause_addr", bus.flash_addr, 23'd2);
    check("pause_nreads", reads_q.size(), 2);
    check("pause_read", bus.flash_read, 1'b0);
    push_word(2, 1'b1); push_word(3, 1'b1);
    enable = 1'b1;
    wait_done("resume_done");
    check("resume_nreads", reads_q.size(), 4);
    check("resume_addr2", reads_q.size() > 2 ? reads_q[2] : 23'h7FFFFF, 23'd2);
    check("resume_empty", exp_q.size(), 0);

    // Reset during REQ, then a stray readdatavalid.
    reads_q.delete();
    tick_period = 0;
    direction = 1'b0;
    pulse_restart();
    for (int i = 0; i < 10 && bus.flash_read !== 1'b1; i++) cyc();
    check("rreq_read", bus.flash_read, 1'b1);
    check("rreq_addr", bus.flash_addr, 23'd3);
    rst_n = 1'b0;
    #1;
    check("rreq_rst_read", bus.flash_read, 1'b0);
    check("rreq_rst_addr", bus.flash_addr, 23'd0);
    check("rreq_rst_flags", {done, sample_valid, wrapped, underrun}, 4'd0);
    enable = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    snap = und_cnt;
    tick_period = 2;
    inj_rdv = 1'b1;
    cyc();
    inj_rdv = 1'b0;
    cycles(20);
    check("late_rdv_out", sample_out, 8'd0);
    check("late_rdv_read", bus.flash_read, 1'b0);
    check("late_rdv_addr", bus.flash_addr, 23'd0);
    check("idle_no_underrun", und_cnt, snap);
    check("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
